// File: rtl/regfile_2r1w_if.sv
// Register file access bus: two combinational read ports and one write port.
// The master side is the decode/writeback pipeline; the slave side is the register file.
interface regfile_2r1w_if #(
   parameter int XLEN = 32,
   parameter int AW   = 5
);
   logic [AW-1:0]   rs1;
   logic [XLEN-1:0] rdata1;
   logic [AW-1:0]   rs2;
   logic [XLEN-1:0] rdata2;
   logic [AW-1:0]   wreg;
   logic [XLEN-1:0] wdata;
   logic            wen;

   modport master (
      output rs1, rs2, wreg, wdata, wen,
      input  rdata1, rdata2
   );

   modport slave (
      input  rs1, rs2, wreg, wdata, wen,
      output rdata1, rdata2
   );
endinterface

// File: rtl/regfile_2r1w.sv
// RV32 integer register file: x1..x31 stored, x0 hardwired to zero,
// two combinational read ports with same-cycle writeback bypass.
module regfile_2r1w #(
   parameter int XLEN = 32,
   parameter int AW   = 5
) (
   input  logic             clk,
   input  logic             reset_n,
   regfile_2r1w_if.slave    bus
);
   localparam int DEPTH = 2 ** AW;

   // x0 has no storage; reads of address 0 are forced to zero below.
   logic [XLEN-1:0] regs [1:DEPTH-1];

   logic write_ok;
   assign write_ok = bus.wen && (bus.wreg != '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: every entry is reset so no X can leak out of a read before its first write.
         for (int i = 1; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else if (write_ok) begin
         regs[bus.wreg] <= bus.wdata;
      end
   end

   // Decode reads in the same cycle writeback writes, so a matching write bypasses storage.
   always_comb begin
      // NOTE: default first, so every path assigns rdata1 and no latch is inferred.
      bus.rdata1 = '0;
      if (reset_n && (bus.rs1 != '0)) begin
         if (write_ok && (bus.wreg == bus.rs1)) begin
            bus.rdata1 = bus.wdata;
         end else begin
            bus.rdata1 = regs[bus.rs1];
         end
      end
   end

   always_comb begin
      bus.rdata2 = '0;
      if (reset_n && (bus.rs2 != '0)) begin
         if (write_ok && (bus.wreg == bus.rs2)) begin
            bus.rdata2 = bus.wdata;
         end else begin
            bus.rdata2 = regs[bus.rs2];
         end
      end
   end
endmodule

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench for regfile_2r1w: expected read data is queued when a read is
// set up and popped against the combinational outputs shortly afterwards.
module tb_regfile_2r1w;
   localparam int XLEN = 32;
   localparam int AW   = 5;

   logic clk;
   logic reset_n;

   regfile_2r1w_if #(.XLEN(XLEN), .AW(AW)) rf_if ();

   regfile_2r1w #(.XLEN(XLEN), .AW(AW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (rf_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string           tag;
      logic [XLEN-1:0] e1;
      logic [XLEN-1:0] e2;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic compare_out();
      exp_t e;
      e = sb.pop_front();
      check({e.tag, "/rdata1"}, rf_if.rdata1, e.e1);
      check({e.tag, "/rdata2"}, rf_if.rdata2, e.e2);
   endtask

   // Drive both read addresses, queue the expected data, sample 1 time unit later.
   task automatic probe(input string tag, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                        input logic [XLEN-1:0] e1, input logic [XLEN-1:0] e2);
      exp_t e;
      rf_if.rs1 = a1;
      rf_if.rs2 = a2;
      e.tag = tag;
      e.e1  = e1;
      e.e2  = e2;
      sb.push_back(e);
      #1;
      compare_out();
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
      @(negedge clk);
      rf_if.wen   = 1'b1;
      rf_if.wreg  = a;
      rf_if.wdata = d;
      @(posedge clk);
      @(negedge clk);
      rf_if.wen = 1'b0;
   endtask

   function automatic logic [XLEN-1:0] sweep_val(input int i);
      return (i == 0) ? '0 : 32'(i) * 32'h0101_0101;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n     = 1'b0;
      rf_if.rs1   = '0;
      rf_if.rs2   = '0;
      rf_if.wen   = 1'b1;
      rf_if.wreg  = 5'd5;
      rf_if.wdata = 32'hAAAA_5555;

      // Reset: outputs zero, bypass suppressed, the write on this edge ignored.
      @(negedge clk);
      probe("reset_hold", 5'd5, 5'd31, '0, '0);
      @(posedge clk);
      @(negedge clk);
      rf_if.wen = 1'b0;
      reset_n   = 1'b1;
      probe("reset_release", 5'd5, 5'd31, '0, '0);

      // Basic write then read on both ports.
      do_write(5'd3, 32'hDEAD_BEEF);
      probe("basic_x3", 5'd3, 5'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      probe("basic_x4", 5'd4, 5'd3, '0, 32'hDEAD_BEEF);

      // Writes to x0 are discarded and never bypassed.
      @(negedge clk);
      rf_if.wen   = 1'b1;
      rf_if.wreg  = 5'd0;
      rf_if.wdata = 32'hFFFF_FFFF;
      probe("x0_during", 5'd0, 5'd0, '0, '0);
      @(posedge clk);
      #1;
      probe("x0_after_edge", 5'd0, 5'd3, '0, 32'hDEAD_BEEF);
      @(negedge clk);
      rf_if.wen = 1'b0;
      probe("x0_idle", 5'd0, 5'd3, '0, 32'hDEAD_BEEF);

      // Same-cycle bypass wins over the stored value.
      do_write(5'd7, 32'h1111_1111);
      do_write(5'd8, 32'h8888_8888);
      @(negedge clk);
      rf_if.wen   = 1'b1;
      rf_if.wreg  = 5'd7;
      rf_if.wdata = 32'h2222_2222;
      probe("bypass", 5'd7, 5'd8, 32'h2222_2222, 32'h8888_8888);
      probe("bypass_same", 5'd7, 5'd7, 32'h2222_2222, 32'h2222_2222);
      @(negedge clk);
      rf_if.wen = 1'b0;
      probe("bypass_stored", 5'd7, 5'd8, 32'h2222_2222, 32'h8888_8888);

      // wen=0 neither bypasses nor writes.
      rf_if.wreg  = 5'd7;
      rf_if.wdata = 32'h3333_3333;
      probe("no_wen_bypass", 5'd7, 5'd8, 32'h2222_2222, 32'h8888_8888);
      @(posedge clk);
      @(negedge clk);
      probe("no_wen_write", 5'd7, 5'd8, 32'h2222_2222, 32'h8888_8888);

      // Asynchronous reset pulse between clock edges.
      do_write(5'd10, 32'h1234_5678);
      probe("pre_async", 5'd10, 5'd7, 32'h1234_5678, 32'h2222_2222);
      reset_n = 1'b0;
      probe("async_reset", 5'd10, 5'd7, '0, '0);
      reset_n = 1'b1;
      probe("async_release", 5'd10, 5'd7, '0, '0);
      @(posedge clk);
      @(negedge clk);
      probe("async_after_edge", 5'd3, 5'd8, '0, '0);

      // Full sweep of all registers through both ports.
      for (int i = 1; i < 32; i++) begin
         do_write(5'(i), sweep_val(i));
      end
      for (int i = 0; i < 32; i++) begin
         probe($sformatf("sweep_%0d", i), 5'(i), 5'(31 - i), sweep_val(i), sweep_val(31 - i));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- Integer register file for the RV32 pipeline: 32 x 32-bit registers, two combinational read ports, one synchronous write port.
- Instantiated in the decode stage. Reads are addressed by the rs1/rs2 fields of the instruction in decode. Writes come from the writeback stage.
- x0 is hardwired to zero.
- Write-to-read bypass is internal. The forwarding network only covers execute and memory, so a writeback in the same cycle must be visible to decode.

Parameters:
- XLEN, 32, data width of each register and of the data ports.
- AW, 5, register address width; depth is 2**AW = 32 entries.

Ports:
- clk  input  1  clock; all writes on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- rs1  input  AW  read port 1 address.
- rdata1  output  XLEN  read port 1 data, combinational.
- rs2  input  AW  read port 2 address.
- rdata2  output  XLEN  read port 2 data, combinational.
- wreg  input  AW  write address.
- wdata  input  XLEN  write data.
- wen  input  1  write enable.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (reset_n).
- Storage: registers x1..x31, each XLEN bits. x0 is not stored.
- Reset:
  - reset_n low immediately clears x1..x31 to 0, independent of clk.
  - While reset_n is low, rdata1 and rdata2 are 0 and writes are ignored.
- Write: on the rising clk edge with reset_n high, wen=1 and wreg!=0, regs[wreg] <= wdata.
  - wreg=0 with wen=1 is silently discarded.
  - wen=0 leaves all state unchanged.
- Read, per port, evaluated combinationally:
  - Address 0 returns 0, always, regardless of any write to x0.
  - Else, if wen=1 and wreg equals the read address, return wdata (same-cycle bypass; zero extra latency).
  - Else return the stored value of the addressed register.
  - Both ports resolve independently. rs1==rs2 is legal, and both return the same value.
- Latency:
  - Read: 0 cycles; rdata follows rs/wreg/wdata/wen with no clock.
  - Write: visible through storage from the cycle after the edge, and through the bypass during the write cycle itself.
- Priority when a write and a bypassable read coincide: the bypass value (wdata) wins over the stale stored value.
- Reset asserted mid-operation: any write on the same edge is lost; all stored registers read 0 after reset_n returns high.
- No X propagation: every register holds a defined value after reset.

Test Plan:
- Reset: hold reset_n=0, drive rs1=5, rs2=31 -> rdata1=rdata2=0. Release, no writes -> still 0.
- Basic write/read: wen=1, wreg=3, wdata=0xDEADBEEF for one edge, then wen=0, rs1=3, rs2=3 -> both read 0xDEADBEEF; rs1=4 -> 0.
- x0 immutability: wen=1, wreg=0, wdata=0xFFFFFFFF, rs1=0 during and after the edge -> rdata1=0 throughout.
- Bypass:
  - Setup: x7=0x11111111 stored.
  - Same cycle: wen=1, wreg=7, wdata=0x22222222, rs1=7, rs2=8 -> rdata1=0x22222222 before the edge, rdata2=stored x8.
  - After the edge with wen=0: rdata1=0x22222222.
- Async reset mid-run: x10=0x12345678 stored, then pulse reset_n low between clock edges -> rdata(rs=10) goes to 0 without a clk edge; remains 0 after release.
- Full sweep: write x1..x31 with value (i*0x01010101), then read all pairs (rs1=i, rs2=31-i) -> expected values; x0 reads 0.
